// File: rtl/d_latch.sv
// d_latch: level-sensitive D latch with asynchronous active-low clear.
// ACTIVE_HIGH chooses which CK level makes the latch transparent.
module d_latch #(
  parameter int WIDTH       = 1,
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic             CK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);
  logic w_open;
  assign w_open = ACTIVE_HIGH ? CK : ~CK;
  // always_latch marks Q as deliberate level-sensitive storage; clear wins over transparency
  always_latch
    if (!RST_N) Q <= '0;
    else if (w_open) Q <= D;
endmodule

// File: tb/tb_d_latch.sv
// tb_d_latch: directed waveform checks plus randomized data/reset traffic
// against a time-sampled reference model, across four latch configurations.
module tb_d_latch;
  logic       ck, ck_n, rst_n, d1;
  logic [7:0] d8, d3;
  logic       q1;
  logic [7:0] q8a, q8b, q8c;
  logic       m1;
  logic [7:0] m8a, m8b, m8c;
  int         n_chk, n_fail;

  assign ck_n = ~ck;

  d_latch #(.WIDTH(1), .ACTIVE_HIGH(1'b1)) u0 (.CK(ck),   .RST_N(rst_n), .D(d1), .Q(q1));
  d_latch #(.WIDTH(8), .ACTIVE_HIGH(1'b1)) u1 (.CK(ck),   .RST_N(rst_n), .D(d8), .Q(q8a));
  d_latch #(.WIDTH(8), .ACTIVE_HIGH(1'b0)) u2 (.CK(ck_n), .RST_N(rst_n), .D(d8), .Q(q8b));
  d_latch #(.WIDTH(8), .ACTIVE_HIGH(1'b0)) u3 (.CK(ck),   .RST_N(rst_n), .D(d3), .Q(q8c));

  initial ck = 1'b1;
  always #50 ck = ~ck;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Stimulus only moves on even ns; the model samples settled inputs on odd ns,
  // so the latch state is the last value seen while open and out of reset.
  initial begin
    #1;
    forever begin
      if (!rst_n) begin
        m1 = 1'b0; m8a = '0; m8b = '0; m8c = '0;
      end else begin
        if (ck) begin m1 = d1; m8a = d8; m8b = d8; end
        if (!ck) m8c = d3;
      end
      chk("q1", 8'(q1), 8'(m1));
      chk("q8_high", q8a, m8a);
      chk("q8_inv_ck", q8b, m8b);
      chk("q8_low", q8c, m8c);
      #2;
    end
  end

  // Hand-derived waveform points for the 1-bit and 8-bit (A5/5A) latches.
  int         t_pt [13] = '{45, 91, 101, 171, 201, 291, 301, 425, 501, 575, 601, 621, 631};
  logic       e1_pt[13] = '{1, 1, 0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 1};
  logic [7:0] e8_pt[13] = '{8'hA5, 8'hA5, 8'h5A, 8'hA5, 8'hA5, 8'h5A, 8'hA5,
                            8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 8'hA5};
  initial begin
    for (int i = 0; i < 13; i++) begin
      #(t_pt[i] - $time);
      chk("pt_q1", 8'(q1), 8'(e1_pt[i]));
      chk("pt_q8", q8a, e8_pt[i]);
      chk("pt_q8_inv", q8b, e8_pt[i]);
    end
  end

  task automatic set_d(input logic v);
    d1 = v;
    d8 = v ? 8'hA5 : 8'h5A;
  endtask

  initial begin
    rst_n = 1'b0; d3 = 8'h3C;
    set_d(1'b0);
    #2   rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      #(40 * k - $time);
      set_d(k[0]);
    end
    #(420 - $time) rst_n = 1'b0;
    #20 set_d(1'b0);
    #40 set_d(1'b1);
    #40 set_d(1'b0);
    #40 set_d(1'b1);
    #10 rst_n = 1'b1;
    #50 rst_n = 1'b0;
    #10 rst_n = 1'b1;
    #10 set_d(1'b0);
    #(700 - $time);
    for (int k = 0; k < 400; k++) begin
      int dly;
      dly = 2 * $urandom_range(1, 15);
      if ((($time + dly) % 50) == 0) dly += 2;
      #dly;
      case ($urandom_range(0, 9))
        0:       rst_n = ~rst_n;
        1, 2:    d3 = 8'($urandom);
        3:       begin d1 = 1'($urandom); d3 = 8'($urandom); end
        default: begin d1 = 1'($urandom); d8 = 8'($urandom); end
      endcase
    end
    rst_n = 1'b1;
    #101;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
